// File: rtl/poly_tone_synth.sv
// Polyphonic square-wave synthesiser: per-voice note divider and envelope FSM,
// summed into a single PWM bitstream for the Pmod amplifier.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | voice silent, level held at 0
// ATTACK  | level ramps up by ATTACK_STEP per envelope tick
// SUSTAIN | level held at full scale while the key is held
// RELEASE | level ramps down by RELEASE_STEP per tick, back to IDLE at 0
module poly_tone_synth #(
    parameter int   VOICES       = 4,
    parameter int   PWM_W        = 8,
    parameter int   ENV_DIV      = 100000,
    parameter int   ATTACK_STEP  = 8,
    parameter int   RELEASE_STEP = 2,
    parameter int   DIV_SHIFT    = 0,
    parameter logic GAIN_LOW     = 1'b1
) (
    input  logic                  clk_100M,
    input  logic                  rst_n,
    input  logic [VOICES-1:0]     key_on,
    input  logic [3*VOICES-1:0]   note,
    input  logic [3*VOICES-1:0]   octave,
    output logic                  AIN,
    output logic                  GAIN,
    output logic                  NC,
    output logic                  ACTIVE
);

    localparam int MIX_W = PWM_W + $clog2(VOICES);
    localparam int PRE_W = $clog2(ENV_DIV + 1);

    localparam logic [PWM_W-1:0] FULL     = '1;
    localparam logic [PWM_W:0]   FULL_X   = {1'b0, FULL};
    localparam logic [PWM_W:0]   A_STEP_X = (PWM_W+1)'(ATTACK_STEP);
    localparam logic [PWM_W-1:0] A_STEP   = PWM_W'(ATTACK_STEP);
    localparam logic [PWM_W-1:0] R_STEP   = PWM_W'(RELEASE_STEP);
    localparam logic [PRE_W-1:0] PRE_LOAD = PRE_W'(ENV_DIV - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ATTACK  = 2'd1,
        SUSTAIN = 2'd2,
        RELEASE = 2'd3
    } state_t;

    function automatic logic [31:0] base_hp(input logic [2:0] n);
        case (n)
            3'd1:    base_hp = 32'd1528902;
            3'd2:    base_hp = 32'd1362097;
            3'd3:    base_hp = 32'd1213491;
            3'd4:    base_hp = 32'd1145383;
            3'd5:    base_hp = 32'd1020420;
            3'd6:    base_hp = 32'd909091;
            3'd7:    base_hp = 32'd809908;
            default: base_hp = '1;
        endcase
    endfunction

    logic [31:0]      hp      [VOICES];
    logic [31:0]      hp_next [VOICES];
    logic [31:0]      cnt     [VOICES];
    logic [PWM_W-1:0] level   [VOICES];
    logic [PWM_W-1:0] lvl_up  [VOICES];
    logic [PWM_W-1:0] lvl_dn  [VOICES];
    state_t           state   [VOICES];
    logic [VOICES-1:0] sq;
    logic [VOICES-1:0] gate;

    logic [PRE_W-1:0] presc;
    logic             tick;
    logic [MIX_W-1:0] mix;
    logic [MIX_W-1:0] pcnt;
    logic [MIX_W-1:0] duty;
    logic             any_busy;

    assign GAIN = GAIN_LOW;
    assign NC   = 1'b0;
    assign tick = (presc == '0);

    always_comb begin
        gate     = '0;
        mix      = '0;
        any_busy = 1'b0;
        for (int v = 0; v < VOICES; v++) begin
            gate[v]    = key_on[v] && (note[3*v +: 3] != 3'd0);
            hp_next[v] = (note[3*v +: 3] == 3'd0) ? '1 :
                         base_hp(note[3*v +: 3]) >> (32'(octave[3*v +: 3]) + 32'(DIV_SHIFT));
            // Saturating ramps; the widened sum catches overflow past full scale.
            lvl_up[v]  = (({1'b0, level[v]} + A_STEP_X) > FULL_X) ? FULL : level[v] + A_STEP;
            lvl_dn[v]  = (level[v] < R_STEP) ? '0 : level[v] - R_STEP;
            mix        = mix + (sq[v] ? MIX_W'(level[v]) : '0);
            if (state[v] != IDLE)
                any_busy = 1'b1;
        end
    end

    always_ff @(posedge clk_100M) begin
        if (!rst_n) begin
            sq <= '0;
            for (int v = 0; v < VOICES; v++) begin
                hp[v]    <= '0;
                cnt[v]   <= '0;
                level[v] <= '0;
                state[v] <= IDLE;
            end
        end else begin
            for (int v = 0; v < VOICES; v++) begin
                hp[v] <= hp_next[v];
                // >= rather than == so a shrinking half-period toggles at once
                if (cnt[v] >= hp[v]) begin
                    sq[v]  <= ~sq[v];
                    cnt[v] <= 32'd1;
                end else begin
                    cnt[v] <= cnt[v] + 32'd1;
                end

                case (state[v])
                    IDLE: begin
                        level[v] <= '0;
                        if (gate[v])
                            state[v] <= ATTACK;
                    end
                    ATTACK: begin
                        if (!gate[v]) begin
                            state[v] <= RELEASE;
                        end else if (level[v] == FULL) begin
                            state[v] <= SUSTAIN;
                        end else if (tick) begin
                            level[v] <= lvl_up[v];
                            if (lvl_up[v] == FULL)
                                state[v] <= SUSTAIN;
                        end
                    end
                    SUSTAIN: begin
                        level[v] <= FULL;
                        if (!gate[v])
                            state[v] <= RELEASE;
                    end
                    RELEASE: begin
                        if (gate[v])
                            state[v] <= ATTACK;
                        else if (level[v] == '0)
                            state[v] <= IDLE;
                        else if (tick)
                            level[v] <= lvl_dn[v];
                    end
                    default: state[v] <= IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk_100M) begin
        if (!rst_n) begin
            presc  <= '0;
            pcnt   <= '0;
            duty   <= '0;
            AIN    <= 1'b0;
            ACTIVE <= 1'b0;
        end else begin
            presc  <= tick ? PRE_LOAD : presc - 1'b1;
            pcnt   <= pcnt + 1'b1;
            if (&pcnt)
                duty <= mix;
            AIN    <= (pcnt < duty);
            ACTIVE <= any_busy;
        end
    end

endmodule

// File: tb/tb_poly_tone_synth.sv
// Self-checking bench for poly_tone_synth: expected values are queued when
// stimulus is applied and compared as the design produces them.
module tb_poly_tone_synth;

    localparam int VOICES = 4;

    logic                  clk_100M = 1'b0;
    logic                  rst_n;
    logic [VOICES-1:0]     key_on;
    logic [3*VOICES-1:0]   note;
    logic [3*VOICES-1:0]   octave;
    logic                  AIN, GAIN, NC, ACTIVE;

    int n_checks = 0;
    int n_pass   = 0;
    string exp_tag [$];
    int    exp_val [$];

    poly_tone_synth #(
        .VOICES(VOICES), .PWM_W(8), .ENV_DIV(4), .ATTACK_STEP(64),
        .RELEASE_STEP(64), .DIV_SHIFT(10), .GAIN_LOW(1'b1)
    ) dut (
        .clk_100M(clk_100M), .rst_n(rst_n), .key_on(key_on), .note(note),
        .octave(octave), .AIN(AIN), .GAIN(GAIN), .NC(NC), .ACTIVE(ACTIVE)
    );

    always #5 clk_100M = ~clk_100M;

    task automatic check(input string tag, input int obs, input int exp_v);
        n_checks++;
        if (obs == exp_v) n_pass++;
        else $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp_v);
    endtask

    task automatic push_exp(input string tag, input int v);
        exp_tag.push_back(tag);
        exp_val.push_back(v);
    endtask

    task automatic pop_cmp(input int obs);
        if (exp_val.size() == 0) check("sb_underflow", 1, 0);
        else check(exp_tag.pop_front(), obs, exp_val.pop_front());
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk_100M);
            #1;
        end
    endtask

    task automatic set_voice(input int v, input logic k, input logic [2:0] n, input logic [2:0] o);
        key_on[v]      = k;
        note[3*v +: 3]   = n;
        octave[3*v +: 3] = o;
    endtask

    task automatic hard_reset();
        rst_n  = 1'b0;
        key_on = '0;
        note   = '0;
        octave = '0;
        step(2);
        rst_n = 1'b1;
        step(1);
    endtask

    task automatic wait_toggle(output int cyc);
        logic prev;
        prev = dut.sq[0];
        cyc  = 0;
        while (1) begin
            step(1);
            cyc++;
            if (dut.sq[0] != prev) break;
            if (cyc >= 2000) begin
                check("toggle_timeout", 0, 1);
                break;
            end
        end
    endtask

    task automatic wait_level(input int v, output int lvl);
        int prev;
        int cyc;
        prev = int'(dut.level[v]);
        cyc  = 0;
        lvl  = -1;
        while (1) begin
            step(1);
            cyc++;
            if (int'(dut.level[v]) != prev) begin
                lvl = int'(dut.level[v]);
                break;
            end
            if (cyc >= 100) begin
                check("level_timeout", 0, 1);
                break;
            end
        end
    endtask

    task automatic wait_state(input int v, input int st);
        int cyc;
        cyc = 0;
        while (int'(dut.state[v]) != st) begin
            step(1);
            cyc++;
            if (cyc >= 200) begin
                check("state_timeout", int'(dut.state[v]), st);
                break;
            end
        end
    endtask

    task automatic expect_levels(input int v, input int a, input int b, input int c, input int d, input int cnt);
        int lvl;
        int seq [4];
        seq = '{a, b, c, d};
        for (int i = 0; i < cnt; i++) push_exp($sformatf("level_v%0d_%0d", v, i), seq[i]);
        for (int i = 0; i < cnt; i++) begin
            wait_level(v, lvl);
            pop_cmp(lvl);
        end
    endtask

    initial begin
        int c;
        int highs;
        int cyc;

        rst_n  = 1'b0;
        key_on = '1;
        note   = {VOICES{3'd1}};
        octave = '0;

        // Reset held with every key down
        for (int i = 0; i < 5; i++) begin
            push_exp("rst_ain", 0); push_exp("rst_active", 0);
            push_exp("rst_gain", 1); push_exp("rst_nc", 0);
            step(1);
            pop_cmp(int'(AIN)); pop_cmp(int'(ACTIVE)); pop_cmp(int'(GAIN)); pop_cmp(int'(NC));
        end
        rst_n = 1'b1;
        push_exp("post_rst_ain", 0); push_exp("post_rst_active", 0);
        step(1);
        pop_cmp(int'(AIN)); pop_cmp(int'(ACTIVE));
        push_exp("active_k2", 1);
        step(1);
        pop_cmp(int'(ACTIVE));

        // Pitch
        hard_reset();
        set_voice(0, 1'b1, 3'd6, 3'd3);
        push_exp("hp_oct3", 110);
        step(2);
        pop_cmp(int'(dut.hp[0]));
        wait_toggle(c); wait_toggle(c);
        push_exp("period_oct3_a", 110); push_exp("period_oct3_b", 110);
        wait_toggle(c); pop_cmp(c);
        wait_toggle(c); pop_cmp(c);
        set_voice(0, 1'b1, 3'd6, 3'd4);
        push_exp("hp_oct4", 55);
        step(1);
        pop_cmp(int'(dut.hp[0]));
        wait_toggle(c); wait_toggle(c);
        push_exp("period_oct4_a", 55); push_exp("period_oct4_b", 55);
        wait_toggle(c); pop_cmp(c);
        wait_toggle(c); pop_cmp(c);

        // Envelope
        hard_reset();
        set_voice(0, 1'b1, 3'd1, 3'd0);
        expect_levels(0, 64, 128, 192, 255, 4);
        step(1);
        push_exp("env_sustain", 2);
        pop_cmp(int'(dut.state[0]));
        set_voice(0, 1'b0, 3'd1, 3'd0);
        expect_levels(0, 191, 127, 63, 0, 4);
        push_exp("env_idle", 0); push_exp("env_active_hold", 1);
        step(1);
        pop_cmp(int'(dut.state[0])); pop_cmp(int'(ACTIVE));
        push_exp("env_active_drop", 0);
        step(1);
        pop_cmp(int'(ACTIVE));

        // Retrigger from the middle of a release
        set_voice(0, 1'b1, 3'd1, 3'd0);
        expect_levels(0, 64, 128, 192, 255, 4);
        step(1);
        set_voice(0, 1'b0, 3'd1, 3'd0);
        expect_levels(0, 191, 127, 0, 0, 2);
        set_voice(0, 1'b1, 3'd1, 3'd0);
        expect_levels(0, 191, 255, 0, 0, 2);
        step(1);
        push_exp("retrig_sustain", 2);
        pop_cmp(int'(dut.state[0]));

        // Mix and PWM with all voices at full scale
        hard_reset();
        for (int v = 0; v < VOICES; v++) set_voice(v, 1'b1, 3'd1, 3'd0);
        cyc = 0;
        while (!((&dut.pcnt) && (dut.sq == 4'hF) && (int'(dut.state[0]) == 2) &&
                 (int'(dut.state[1]) == 2) && (int'(dut.state[2]) == 2) && (int'(dut.state[3]) == 2))) begin
            step(1);
            cyc++;
            if (cyc >= 20000) begin
                check("frame_timeout", 0, 1);
                break;
            end
        end
        push_exp("duty_full", 1020); push_exp("ain_high_full", 1020);
        step(1);
        pop_cmp(int'(dut.duty));
        highs = 0;
        for (int i = 0; i < 1024; i++) begin
            step(1);
            highs += int'(AIN);
        end
        pop_cmp(highs);

        for (int v = 0; v < VOICES; v++) set_voice(v, 1'b0, 3'd1, 3'd0);
        cyc = 0;
        while (ACTIVE) begin
            step(1);
            cyc++;
            if (cyc >= 300) begin
                check("silence_timeout", 1, 0);
                break;
            end
        end
        step(1100);
        push_exp("duty_silent", 0); push_exp("ain_high_silent", 0);
        pop_cmp(int'(dut.duty));
        highs = 0;
        for (int i = 0; i < 1024; i++) begin
            step(1);
            highs += int'(AIN);
        end
        pop_cmp(highs);

        // Note 0 never starts a voice; switching to it releases
        hard_reset();
        set_voice(1, 1'b1, 3'd0, 3'd2);
        step(20);
        push_exp("note0_idle", 0); push_exp("note0_active", 0);
        pop_cmp(int'(dut.state[1])); pop_cmp(int'(ACTIVE));
        set_voice(1, 1'b1, 3'd2, 3'd0);
        wait_state(1, 2);
        set_voice(1, 1'b1, 3'd0, 3'd0);
        push_exp("note0_release", 3);
        step(1);
        pop_cmp(int'(dut.state[1]));

        // Reset mid-note: silenced on the next edge, no ramp
        rst_n = 1'b0;
        push_exp("midrst_level", 0); push_exp("midrst_state", 0); push_exp("midrst_active", 0);
        push_exp("midrst_gain", 1); push_exp("midrst_nc", 0);
        step(1);
        pop_cmp(int'(dut.level[1])); pop_cmp(int'(dut.state[1])); pop_cmp(int'(ACTIVE));
        pop_cmp(int'(GAIN)); pop_cmp(int'(NC));
        rst_n = 1'b1;

        if (exp_val.size() != 0) check("sb_leftover", exp_val.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
